clken_nco: RTL
==============

# clken_nco

Multi-channel numerically controlled clock-enable generator. Runs entirely in the single reference clock domain and produces one-cycle clock-enable pulses at arbitrary fractional rates, e.g. 25.116279 MHz pixel and 4 MHz CPU enables from a 50 MHz clock. It succeeds the fixed two-output PLL wrapper: channel count and accumulator width are parametrised, rates are retunable at run time, and it reports a PLL-style `locked`. Consumers gate their logic with `ce[i]` instead of running on derived clocks.

## Interface
- `NUM_CH`, 2, number of enable channels (1..16).
- `ACC_W`, 32, phase accumulator width per channel (16..48).
- `INIT_INC`, {32'h147AE148, 32'h809868C8}, packed reset increments, `NUM_CH*ACC_W` bits; channel i is bits `[i*ACC_W +: ACC_W]`.
- `LOCK_CYCLES`, 16, settle cycles before `locked` asserts (1..65535).

Ports:
- `refclk` in 1: sole clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_valid` in 1: retune request valid.
- `cfg_ready` out 1: block can accept a retune.
- `cfg_ch` in 4: target channel index.
- `cfg_inc` in ACC_W: new phase increment; output rate = f_refclk·inc/2^ACC_W.
- `cfg_err` out 1: one-cycle pulse when an accepted request had `cfg_ch >= NUM_CH`.
- `ce` out NUM_CH: per-channel enable pulses, registered.
- `sq` out NUM_CH: accumulator MSB per channel, approximately 50 % duty.
- `locked` out 1: all channels running at their programmed rates.

## Operation
- **Reset** (`rst` high at an edge):
  - `acc[i]` = 0 and `inc[i]` = `INIT_INC[i]`.
  - `ce`, `sq`, `cfg_err`, `locked` = 0; `cfg_ready` = 0.
  - FSM goes to SETTLE; the lock counter clears.
- **Each cycle, per channel:** `{carry, acc'} = acc + inc`, computed as ACC_W+1-bit unsigned with wrap-around. `ce[i]` is registered from `carry`; `sq[i]` is registered from `acc'[ACC_W-1]`.
- **inc = 0:** channel is idle; `ce` and `sq` stay 0.
- **FSM:**
  - SETTLE: counts `LOCK_CYCLES` cycles, then goes to LOCKED.
  - LOCKED: `locked` = 1, `cfg_ready` = 1. On `cfg_valid && cfg_ready` the request is captured and the FSM goes to PENDING. `locked` drops on the next edge.
  - PENDING: `cfg_ready` = 0. The captured increment is applied according to the configuration mode. The FSM then goes to SETTLE with a cleared counter.
- **Invalid channel:** a request with `cfg_ch >= NUM_CH` is accepted. `cfg_err` pulses the following cycle, no increment changes, and the FSM stays in LOCKED.
- **Retune timing:** `acc` is never cleared by a retune, so phase stays continuous.
- **Simultaneous events:** `rst` overrides any retune; a request in the reset cycle is dropped. `cfg_ready` is 0 in SETTLE and PENDING, so only one retune can be outstanding.

## Timing
- **First enable:** `ce[i]` first goes high on the edge where the accumulator first overflows. With inc = 2^(ACC_W-1) that is the 2nd edge after `rst` falls, and the pattern is 0,1,0,1…
- **Latency:** one register stage from accumulator overflow to `ce`.
- **Lock after reset:** `locked` rises `LOCK_CYCLES` + 1 edges after the last reset edge.
- **Immediate retune:** the new increment takes effect on the 2nd edge after acceptance. `locked` returns `LOCK_CYCLES` + 2 edges after acceptance.
- **Aligned retune:** the new increment is loaded on the edge where the target channel's carry occurs, so the old rate finishes its current period.

## Configuration
- **`CLKEN_RETUNE_ALIGN_EN` defined:**
  - PENDING waits for the target channel's carry, then loads `inc` on that same edge. This avoids a short or long period straddling the change.
  - If the current `inc` is 0, the increment is loaded immediately.
- **Undefined:** PENDING lasts exactly one cycle and `inc` loads unconditionally. The straddling period may be shortened.

## Test plan
- **Reset defaults:** release reset with ACC_W = 32 and default `INIT_INC`.
  - `locked` rises at edge 17.
  - ch1 `ce` averages 8 pulses per 100 cycles (4 MHz).
  - ch0 `ce` averages 50.23 pulses per 100 cycles over 43 000 cycles.
- **Exact patterns and idle channel:**
  - inc = 0x80000000 gives `ce` = 0,1,0,1…
  - inc = 0x40000000 gives one pulse every 4 cycles, with `sq` high for 2 of every 4 cycles.
  - inc = 0 keeps `ce` and `sq` at 0 indefinitely.
- **Aligned retune** (`CLKEN_RETUNE_ALIGN_EN`): channel at 0x20000000, retune to 0x80000000 mid-period.
  - `cfg_ready` stays 0 until the next ch carry.
  - Pulse spacing goes 8 then 2 with no intermediate period.
  - `locked` is low from acceptance+1 until `LOCK_CYCLES` after the load.
- **Immediate retune** (macro undefined): the same stimulus loads the new increment on the 2nd edge after acceptance, and `locked` returns at acceptance + 18.
- **Invalid channel:** `cfg_ch` = 5 with NUM_CH = 2 gives a one-cycle `cfg_err`, unchanged rates, and `locked` staying 1.
- **Reset mid-operation:** assert `rst` during PENDING together with `cfg_valid`.
  - All outputs return to their reset values.
  - The increments return to `INIT_INC`; the pending request is discarded.
  - Lock restarts from SETTLE.

Source files
------------

// File: rtl/clken_nco.sv
// clken_nco: multi-channel fractional-rate clock-enable generator (phase-accumulator NCO per channel).
// Latency: one register stage from accumulator overflow to ce/sq; a retune reaches the accumulator 2 edges after acceptance.
// Backpressure: cfg_ready is high only while locked, so at most one retune is outstanding at any time.
//
// Ports:
//   refclk         sole clock, all state on its rising edge
//   rst            synchronous active-high reset
//   cfg_valid/_ready, cfg_ch, cfg_inc   retune request handshake (channel index, new phase increment)
//   cfg_err        one-cycle pulse after an accepted request that named a non-existent channel
//   ce[NUM_CH]     one-cycle enable pulses, rate = f_refclk * inc / 2^ACC_W
//   sq[NUM_CH]     registered accumulator MSB, roughly 50 % duty square wave
//   locked         all channels running at their programmed increments
//
// Build option: define CLKEN_RETUNE_ALIGN_EN to defer a new increment until the target
// channel's next carry, so no shortened or stretched period straddles the change.
// Without it the increment is applied one cycle after acceptance.
`timescale 1ns/1ps

module clken_nco #(
    parameter int unsigned                NUM_CH      = 2,
    parameter int unsigned                ACC_W       = 32,
    parameter logic [NUM_CH*ACC_W-1:0]    INIT_INC    = {32'h147AE148, 32'h809868C8},
    parameter int unsigned                LOCK_CYCLES = 16
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] sq,
    output logic              locked
);

    // Lock counter must hold LOCK_CYCLES itself (up to 65535).
    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] ST_SETTLE  = 2'd0;
    localparam logic [1:0] ST_LOCKED  = 2'd1;
    localparam logic [1:0] ST_PENDING = 2'd2;

    // ------------------------------------------------------------------
    // Per-channel state
    // ------------------------------------------------------------------
    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [ACC_W-1:0]  acc_d [NUM_CH];
    logic [ACC_W-1:0]  inc_q [NUM_CH];
    logic [ACC_W-1:0]  inc_d [NUM_CH];
    logic [NUM_CH-1:0] carry;
    logic [NUM_CH-1:0] ce_q;
    logic [NUM_CH-1:0] sq_q;
    logic [NUM_CH-1:0] sq_d;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [3:0]        ch_q,    ch_d;
    logic [ACC_W-1:0]  new_inc_q, new_inc_d;
    logic              err_q,   err_d;
    logic              load;
    logic              ch_in_range;

    // ------------------------------------------------------------------
    // Phase accumulators: ACC_W+1-bit sum, the extra bit is the overflow
    // that becomes the enable pulse.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [ACC_W:0] sum;

        assign sum      = {1'b0, acc_q[g]} + {1'b0, inc_q[g]};
        assign carry[g] = sum[ACC_W];
        assign acc_d[g] = sum[ACC_W-1:0];
        // An idle channel (inc = 0) may have frozen with its MSB set;
        // force its square output low so idle really means quiet.
        assign sq_d[g]  = sum[ACC_W-1] & (inc_q[g] != '0);
    end

    // Requests naming a channel that does not exist are acknowledged but
    // only flagged, never applied.
    assign ch_in_range = ({1'b0, cfg_ch} < 5'(NUM_CH));

`ifdef CLKEN_RETUNE_ALIGN_EN
    // Carry and idle status of the channel targeted by the pending request.
    logic sel_carry;
    logic sel_zero;

    always_comb begin
        sel_carry = 1'b0;
        sel_zero  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == 4'(i)) begin
                sel_carry = carry[i];
                sel_zero  = (inc_q[i] == '0);
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Lock / retune FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        new_inc_d = new_inc_q;
        err_d     = 1'b0;
        load      = 1'b0;

        case (state_q)
            ST_SETTLE: begin
                // Counter starts at 0 on the entry edge, so LOCKED is
                // reached LOCK_CYCLES+1 edges after entering SETTLE.
                if (cnt_q == CNT_W'(LOCK_CYCLES)) begin
                    state_d = ST_LOCKED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_LOCKED: begin
                // cfg_ready is high in this state, so cfg_valid alone is
                // the handshake.
                if (cfg_valid) begin
                    if (ch_in_range) begin
                        ch_d      = cfg_ch;
                        new_inc_d = cfg_inc;
                        state_d   = ST_PENDING;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_PENDING: begin
`ifdef CLKEN_RETUNE_ALIGN_EN
                // Swap increments on the edge that ends the current period;
                // an idle channel has no period to finish.
                load = sel_carry | sel_zero;
`else
                load = 1'b1;
`endif
                if (load) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Increment update: only the captured channel changes, and only on the
    // load edge. The accumulator still uses the old increment on that edge.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            inc_d[i] = inc_q[i];
            if (load && (ch_q == 4'(i))) begin
                inc_d[i] = new_inc_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                inc_q[i] <= INIT_INC[i*ACC_W +: ACC_W];
            end
            ce_q      <= '0;
            sq_q      <= '0;
            state_q   <= ST_SETTLE;
            cnt_q     <= '0;
            ch_q      <= '0;
            new_inc_q <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= acc_d[i];
                inc_q[i] <= inc_d[i];
            end
            ce_q      <= carry;
            sq_q      <= sq_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            new_inc_q <= new_inc_d;
            err_q     <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ce        = ce_q;
    assign sq        = sq_q;
    assign cfg_err   = err_q;
    assign locked    = (state_q == ST_LOCKED);
    assign cfg_ready = (state_q == ST_LOCKED);

endmodule
